// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector with a per-channel minimum-hold glitch filter,
// run-time edge selection and a saturating count of reported edges.
module multi_edge_detector #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] edge_y,
    output logic [WIDTH-1:0] rise_y,
    output logic [WIDTH-1:0] fall_y,
    output logic             any_edge,
    output logic [CNT_W-1:0] evt_count
);

    localparam int HW = $clog2(HOLD + 1);
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = CNT_W + PW + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [SW-1:0] CNT_MAX   = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {
        INIT = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t            state_q [WIDTH];
    state_t            state_d [WIDTH];
    logic [HW-1:0]     hold_q  [WIDTH];
    logic [HW-1:0]     hold_d  [WIDTH];
    logic [WIDTH-1:0]  rise_q, rise_d;
    logic [WIDTH-1:0]  fall_q, fall_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic              any_q, any_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     pop;
    logic [SW-1:0]     sum;
    logic              pass_rise, pass_fall;

    always_comb begin
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            if (en) begin
                case (state_q[i])
                    INIT: begin
                        state_d[i] = in_a[i] ? HIGH : LOW;
                        hold_d[i]  = '0;
                    end
                    LOW: begin
                        if (!in_a[i]) begin
                            hold_d[i] = '0;
                        end else if (hold_q[i] == HOLD_LAST) begin
                            state_d[i] = HIGH;
                            hold_d[i]  = '0;
                            rise_d[i]  = 1'b1;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
                    HIGH: begin
                        if (in_a[i]) begin
                            hold_d[i] = '0;
                        end else if (hold_q[i] == HOLD_LAST) begin
                            state_d[i] = LOW;
                            hold_d[i]  = '0;
                            fall_d[i]  = 1'b1;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
                    default: begin
                        state_d[i] = INIT;
                        hold_d[i]  = '0;
                    end
                endcase
            end
        end

        pass_rise = (mode == 2'b00) || (mode == 2'b01);
        pass_fall = (mode == 2'b00) || (mode == 2'b10);
        edge_d    = (rise_d & {WIDTH{pass_rise}}) | (fall_d & {WIDTH{pass_fall}});
        any_d     = |edge_d;

        // Counter saturates rather than wrapping; a clear discards same-cycle edges.
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(edge_d[i]);
        end
        sum = SW'(cnt_q) + SW'(pop);
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            cnt_d = CNT_MAX[CNT_W-1:0];
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= INIT;
                hold_q[i]  <= '0;
            end
            rise_q <= '0;
            fall_q <= '0;
            edge_q <= '0;
            any_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
            rise_q <= rise_d;
            fall_q <= fall_d;
            edge_q <= edge_d;
            any_q  <= any_d;
            cnt_q  <= cnt_d;
        end
    end

    assign edge_y    = edge_q;
    assign rise_y    = rise_q;
    assign fall_y    = fall_q;
    assign any_edge  = any_q;
    assign evt_count = cnt_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: instance A (HOLD=1, CNT_W=3) covers edges, masking, saturation,
// clear/reset collisions and enable gating; instance B (HOLD=3) covers the hold filter.
module tb_multi_edge_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       a_reset, a_en, a_clr;
    logic [1:0] a_mode;
    logic [3:0] a_in, a_edge, a_rise, a_fall;
    logic       a_any;
    logic [2:0] a_cnt;

    logic       b_reset, b_en, b_clr;
    logic [1:0] b_mode;
    logic [3:0] b_in, b_edge, b_rise, b_fall;
    logic       b_any;
    logic [7:0] b_cnt;

    multi_edge_detector #(.WIDTH(4), .HOLD(1), .CNT_W(3)) dut_a (
        .clk(clk), .reset(a_reset), .en(a_en), .mode(a_mode), .in_a(a_in),
        .cnt_clr(a_clr), .edge_y(a_edge), .rise_y(a_rise), .fall_y(a_fall),
        .any_edge(a_any), .evt_count(a_cnt)
    );

    multi_edge_detector #(.WIDTH(4), .HOLD(3), .CNT_W(8)) dut_b (
        .clk(clk), .reset(b_reset), .en(b_en), .mode(b_mode), .in_a(b_in),
        .cnt_clr(b_clr), .edge_y(b_edge), .rise_y(b_rise), .fall_y(b_fall),
        .any_edge(b_any), .evt_count(b_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulusA(input logic rst, input logic en, input logic [1:0] mode,
                                  input logic [3:0] in, input logic clr);
        a_reset = rst; a_en = en; a_mode = mode; a_in = in; a_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulusB(input logic rst, input logic en, input logic [3:0] in);
        b_reset = rst; b_en = en; b_mode = 2'b00; b_in = in; b_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input string tag, input logic [3:0] e, input logic [3:0] r,
                          input logic [3:0] f, input logic any, input logic [2:0] cnt);
        checkOutput({tag, ".edge"}, 32'(a_edge), 32'(e));
        checkOutput({tag, ".rise"}, 32'(a_rise), 32'(r));
        checkOutput({tag, ".fall"}, 32'(a_fall), 32'(f));
        checkOutput({tag, ".any"},  32'(a_any),  32'(any));
        checkOutput({tag, ".cnt"},  32'(a_cnt),  32'(cnt));
    endtask

    task automatic checkB(input string tag, input logic [3:0] r, input logic [3:0] f,
                          input logic [7:0] cnt);
        checkOutput({tag, ".edge"}, 32'(b_edge), 32'(r | f));
        checkOutput({tag, ".rise"}, 32'(b_rise), 32'(r));
        checkOutput({tag, ".fall"}, 32'(b_fall), 32'(f));
        checkOutput({tag, ".cnt"},  32'(b_cnt),  32'(cnt));
    endtask

    initial begin
        a_reset = 1'b0; a_en = 1'b1; a_mode = 2'b00; a_in = '0; a_clr = 1'b0;
        b_reset = 1'b0; b_en = 1'b1; b_mode = 2'b00; b_in = '0; b_clr = 1'b0;

        // Instance A: reset with live inputs, then basic edges
        applyStimulusA(1'b0, 1'b1, 2'b00, 4'hF, 1'b1);
        checkA("a_reset", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h0, 1'b0);
        checkA("a_init", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h0, 1'b0);
        checkA("a_base0", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h1, 1'b0);
        checkA("a_base_rise", 4'h1, 4'h1, 4'h0, 1'b1, 3'd1);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h1, 1'b0);
        checkA("a_base_hold", 4'h0, 4'h0, 4'h0, 1'b0, 3'd1);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h0, 1'b0);
        checkA("a_base_fall", 4'h1, 4'h0, 4'h1, 1'b1, 3'd2);

        // Masking
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h1, 1'b0);
        checkA("a_m00_rise", 4'h1, 4'h1, 4'h0, 1'b1, 3'd3);
        applyStimulusA(1'b1, 1'b1, 2'b01, 4'h0, 1'b0);
        checkA("a_m01_fall", 4'h0, 4'h0, 4'h1, 1'b0, 3'd3);
        applyStimulusA(1'b1, 1'b1, 2'b11, 4'h1, 1'b0);
        checkA("a_m11_rise", 4'h0, 4'h1, 4'h0, 1'b0, 3'd3);
        applyStimulusA(1'b1, 1'b1, 2'b11, 4'h0, 1'b0);
        checkA("a_m11_fall", 4'h0, 4'h0, 4'h1, 1'b0, 3'd3);
        applyStimulusA(1'b1, 1'b1, 2'b10, 4'h1, 1'b0);
        checkA("a_m10_rise", 4'h0, 4'h1, 4'h0, 1'b0, 3'd3);
        applyStimulusA(1'b1, 1'b1, 2'b10, 4'h0, 1'b0);
        checkA("a_m10_fall", 4'h1, 4'h0, 4'h1, 1'b1, 3'd4);

        // Simultaneous edges and saturation
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h0, 1'b1);
        checkA("a_clr_idle", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'hF, 1'b0);
        checkA("a_all_rise", 4'hF, 4'hF, 4'h0, 1'b1, 3'd4);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'hC, 1'b0);
        checkA("a_two_fall", 4'h3, 4'h0, 4'h3, 1'b1, 3'd6);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h3, 1'b0);
        checkA("a_sat", 4'hF, 4'h3, 4'hC, 1'b1, 3'd7);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'hC, 1'b0);
        checkA("a_sat_hold", 4'hF, 4'hC, 4'h3, 1'b1, 3'd7);

        // Clear colliding with edges, then reset while HIGH
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h3, 1'b1);
        checkA("a_clr_edge", 4'hF, 4'h3, 4'hC, 1'b1, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h3, 1'b0);
        checkA("a_pre_rst", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h0, 1'b0);
        checkA("a_pre_rst2", 4'h3, 4'h0, 4'h3, 1'b1, 3'd2);
        applyStimulusA(1'b0, 1'b1, 2'b00, 4'h3, 1'b0);
        checkA("a_rst_mid", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h3, 1'b0);
        checkA("a_rst_rel", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h3, 1'b0);
        checkA("a_rst_rel2", 4'h0, 4'h0, 4'h0, 1'b0, 3'd0);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h2, 1'b0);
        checkA("a_after_rst", 4'h1, 4'h0, 4'h1, 1'b1, 3'd1);

        // Enable gating on channel 1
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h0, 1'b0);
        checkA("a_ch1_fall", 4'h2, 4'h0, 4'h2, 1'b1, 3'd2);
        applyStimulusA(1'b1, 1'b0, 2'b00, 4'h2, 1'b0);
        checkA("a_dis1", 4'h0, 4'h0, 4'h0, 1'b0, 3'd2);
        applyStimulusA(1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
        checkA("a_dis2", 4'h0, 4'h0, 4'h0, 1'b0, 3'd2);
        applyStimulusA(1'b1, 1'b0, 2'b00, 4'h2, 1'b0);
        checkA("a_dis3", 4'h0, 4'h0, 4'h0, 1'b0, 3'd2);
        applyStimulusA(1'b1, 1'b1, 2'b00, 4'h2, 1'b0);
        checkA("a_en_rise", 4'h2, 4'h2, 4'h0, 1'b1, 3'd3);

        // Instance B: hold filter with HOLD=3
        applyStimulusB(1'b0, 1'b1, 4'h0);
        checkB("b_reset", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h0);
        checkB("b_init", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_glitch1", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_glitch2", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h0);
        checkB("b_drop", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_hold1", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_hold2", 4'h0, 4'h0, 8'd0);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_hold3_rise", 4'h1, 4'h0, 8'd1);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_steady", 4'h0, 4'h0, 8'd1);
        applyStimulusB(1'b1, 1'b1, 4'h0);
        checkB("b_fall1", 4'h0, 4'h0, 8'd1);
        applyStimulusB(1'b1, 1'b1, 4'h0);
        checkB("b_fall2", 4'h0, 4'h0, 8'd1);
        applyStimulusB(1'b1, 1'b1, 4'h0);
        checkB("b_fall3", 4'h0, 4'h1, 8'd2);

        // Disabled cycle neither advances nor clears the hold counter
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_gate1", 4'h0, 4'h0, 8'd2);
        applyStimulusB(1'b1, 1'b0, 4'h0);
        checkB("b_gate_off", 4'h0, 4'h0, 8'd2);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_gate2", 4'h0, 4'h0, 8'd2);
        applyStimulusB(1'b1, 1'b1, 4'h1);
        checkB("b_gate3_rise", 4'h1, 4'h0, 8'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
